// File: rtl/sm3_digest_tx.sv
// Captures the 256-bit SM3 digest on a rising edge of done and streams it out MSW first
// as W-bit words over valid/ready. Optional digest compare enabled by SM3_DIGEST_CMP_EN.
module sm3_digest_tx #(
    parameter int W = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [255:0]   i_digest_in,
    input  logic           i_digest_done,
    output logic [W-1:0]   o_tx_data,
    output logic           o_tx_valid,
    input  logic           i_tx_ready,
    output logic           o_tx_last,
    output logic           o_busy,
    output logic           o_overrun
`ifdef SM3_DIGEST_CMP_EN
    ,
    input  logic [255:0]   i_expect_in,
    output logic           o_match,
    output logic           o_match_valid
`endif
);

    localparam int NWORDS = 256 / W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [255:0]       r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done_d;
    logic               r_overrun;

    state_t             w_state_nxt;
    logic [255:0]       w_shift_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_overrun_nxt;
    logic               w_load;
    logic               w_capture;
    logic               w_accept;
    logic               w_last;

    assign w_capture = i_digest_done & ~r_done_d;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_accept  = (r_state == ST_SEND) & i_tx_ready;

    // Next-state, shift register and overrun logic
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_overrun_nxt = r_overrun;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_accept && w_last) begin
                    // A capture landing on the final accept chains straight into the next digest
                    if (w_capture) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_shift_nxt = r_shift << W;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end
                end else begin
                    if (w_accept) begin
                        w_shift_nxt = r_shift << W;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end else begin
                        w_shift_nxt = r_shift;
                    end
                    if (w_capture) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = r_overrun;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_load) begin
            w_shift_nxt = i_digest_in;
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= 256'd0;
            r_cnt     <= {CNT_W{1'b0}};
            r_done_d  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done_d  <= i_digest_done;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign o_tx_data  = r_shift[255 -: W];
    assign o_tx_valid = (r_state == ST_SEND);
    assign o_tx_last  = (r_state == ST_SEND) & w_last;
    assign o_busy     = (r_state == ST_SEND);
    assign o_overrun  = r_overrun;

`ifdef SM3_DIGEST_CMP_EN
    logic r_match;
    logic r_match_valid;

    // Compare only digests that are actually loaded; dropped ones never reach here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_match       <= 1'b0;
            r_match_valid <= 1'b0;
        end else begin
            r_match_valid <= w_load;
            if (w_load) begin
                r_match <= (i_digest_in == i_expect_in);
            end else begin
                r_match <= r_match;
            end
        end
    end

    assign o_match       = r_match;
    assign o_match_valid = r_match_valid;
`endif

endmodule

// File: tb/tb_sm3_digest_tx.sv
// Directed bench for sm3_digest_tx: W=32 and W=8 instances driven with the "abc" digest.
module tb_sm3_digest_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] D =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

    logic         rst;
    logic [255:0] din, din8;
    logic         done, done8, rdy, rdy8;
    logic [31:0]  data;
    logic         valid, last, busy, ovr;
    logic [7:0]   data8;
    logic         valid8, last8, busy8, ovr8;
    logic [15:0]  pat;
    int           acc;
    int           checks   = 0;
    int           failures = 0;
`ifdef SM3_DIGEST_CMP_EN
    logic [255:0] exp_in;
    logic         match, mvalid, match8, mvalid8;
`endif

    sm3_digest_tx #(.W(32)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_digest_in(din), .i_digest_done(done),
        .o_tx_data(data), .o_tx_valid(valid), .i_tx_ready(rdy), .o_tx_last(last),
        .o_busy(busy), .o_overrun(ovr)
`ifdef SM3_DIGEST_CMP_EN
        , .i_expect_in(exp_in), .o_match(match), .o_match_valid(mvalid)
`endif
    );

    sm3_digest_tx #(.W(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_digest_in(din8), .i_digest_done(done8),
        .o_tx_data(data8), .o_tx_valid(valid8), .i_tx_ready(rdy8), .o_tx_last(last8),
        .o_busy(busy8), .o_overrun(ovr8)
`ifdef SM3_DIGEST_CMP_EN
        , .i_expect_in(exp_in), .o_match(match8), .o_match_valid(mvalid8)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [255:0] d, input int i);
        return d[255 - 32*i -: 32];
    endfunction

    function automatic logic [7:0] wb(input logic [255:0] d, input int i);
        return d[255 - 8*i -: 8];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; din = 256'd0; din8 = 256'd0; done = 1'b0; done8 = 1'b0;
        rdy = 1'b0; rdy8 = 1'b0; pat = 16'b1011_0010_1101_0101; acc = 0;
`ifdef SM3_DIGEST_CMP_EN
        exp_in = 256'd0;
`endif
        step(); step();
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data, 32'd0);
        chk("rst_last", last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", ovr, 1'b0);
        rst = 1'b0;
        step();

        // 1: full-throughput stream
        din = D; done = 1'b1; step();
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", valid, 1'b1);
            chk("t1_data", data, wd(D, i));
            chk("t1_last", last, (i == 7));
            step();
        end
        chk("t1_valid_end", valid, 1'b0);
        chk("t1_busy_end", busy, 1'b0);
        done = 1'b0; rdy = 1'b0; step();

        // 2: stalls
        done = 1'b1; step(); done = 1'b0;
        acc = 0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            chk("t2_valid", valid, 1'b1);
            chk("t2_data", data, wd(D, acc));
            chk("t2_last", last, (acc == 7));
            rdy = pat[c % 16];
            step();
            if (rdy) acc++;
        end
        chk("t2_accepts", acc, 8);
        chk("t2_valid_end", valid, 1'b0);
        rdy = 1'b1; step();

        // 3: overrun mid-stream
        done = 1'b1; step(); done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                done = 1'b1; din = ~D;
            end
            chk("t3_data", data, wd(D, i));
            chk("t3_ovr", ovr, (i > 3));
            step();
        end
        chk("t3_valid_end", valid, 1'b0);
        chk("t3_ovr_sticky", ovr, 1'b1);
        done = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        chk("t3_ovr_clr", ovr, 1'b0);

        // 4: back-to-back on final accept
        din = D; done = 1'b1; step(); done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_data_a", data, wd(D, i));
            if (i == 7) begin
                done = 1'b1; din = ~D;
            end
            step();
        end
        for (int j = 0; j < 8; j++) begin
            chk("t4_valid_b", valid, 1'b1);
            chk("t4_data_b", data, wd(~D, j));
            chk("t4_last_b", last, (j == 7));
            chk("t4_ovr", ovr, 1'b0);
            step();
        end
        chk("t4_valid_end", valid, 1'b0);
        done = 1'b0; step();

        // 5: reset mid-transfer then restart
        din = D; done = 1'b1; step(); done = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_word4", data, wd(D, 4));
        rst = 1'b1; step();
        chk("t5_valid", valid, 1'b0);
        chk("t5_data", data, 32'd0);
        chk("t5_last", last, 1'b0);
        chk("t5_busy", busy, 1'b0);
        rst = 1'b0; step();
        chk("t5_idle", valid, 1'b0);
        done = 1'b1; step(); done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_data_r", data, wd(D, i));
            chk("t5_last_r", last, (i == 7));
            step();
        end
        chk("t5_valid_end", valid, 1'b0);

        // W=8 stream
        din8 = D; rdy8 = 1'b1; done8 = 1'b1; step(); done8 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("w8_valid", valid8, 1'b1);
            chk("w8_data", data8, wb(D, i));
            chk("w8_last", last8, (i == 31));
            step();
        end
        chk("w8_valid_end", valid8, 1'b0);
        chk("w8_busy_end", busy8, 1'b0);
        chk("w8_ovr", ovr8, 1'b0);

`ifdef SM3_DIGEST_CMP_EN
        // 6: compare feature
        rdy = 1'b0; din = D; exp_in = D; done = 1'b1; step();
        chk("t6_match", match, 1'b1);
        chk("t6_mvalid", mvalid, 1'b1);
        chk("t6_valid", valid, 1'b1);
        step();
        chk("t6_mvalid_pulse", mvalid, 1'b0);
        chk("t6_match_hold", match, 1'b1);
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) step();
        done = 1'b0; exp_in = D ^ 256'd1; step();
        done = 1'b1; step(); done = 1'b0;
        chk("t6_nomatch", match, 1'b0);
        chk("t6_mvalid2", mvalid, 1'b1);
        for (int i = 0; i < 8; i++) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
